// File: rtl/lfsr_word_gen_pkg.sv
// lfsr_word_gen_pkg
//   Shared types and helpers for the LFSR word generator.
//   state_t   : controller FSM states
//   idx_width : width of the in-word bit index for a given word width
package lfsr_word_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    WAIT
  } state_t;

  // ceil(log2(w)), never less than one bit
  function automatic int unsigned idx_width(input int unsigned w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/lfsr_word_gen_lfsr.sv
// lfsr_word_gen_lfsr
//   Serial LFSR. The register shifts toward bit 0; the feedback bit enters
//   at bit nbits-1. q[0] always feeds back, so tap[0] has no effect.
//   clk  : clock
//   rst  : synchronous, active-high; loads seed
//   en   : advance one step
//   seed : value loaded on rst
//   tap  : feedback tap mask (bit 0 ignored)
//   out  : current serial output, q[0]
module lfsr_word_gen_lfsr #(
  parameter int unsigned nbits = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [nbits-1:0] seed,
  input  logic [nbits-1:0] tap,
  output logic             out
);

  logic [nbits-1:0] q;
  logic [nbits-1:0] tap_eff;
  logic [nbits-1:0] q_next;
  logic             fb;

  always_comb begin
    tap_eff    = tap;
    tap_eff[0] = 1'b0;
    fb         = q[0] ^ (^(q & tap_eff));
    q_next     = q >> 1;
    q_next[nbits-1] = fb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= seed;
    end else if (en) begin
      q <= q_next;
    end
  end

  assign out = q[0];

endmodule

// File: rtl/lfsr_word_gen.sv
// lfsr_word_gen
//   Command-driven controller around an LFSR: latches taps/seed/word count,
//   seeds the LFSR, then packs its serial output LSB-first into wbits-wide
//   words delivered on a valid/ready stream. The LFSR only advances while a
//   word is being assembled, so backpressure never drops or skips bits.
//   clk, rst          : clock, asynchronous active-low reset
//   cfg_val/cfg_rdy   : configuration handshake (ready only in IDLE)
//   cfg_tap/cfg_seed  : LFSR tap mask and seed
//   cfg_nwords        : number of words to produce (0 completes at once)
//   abort             : cancel the current run, no done pulse
//   out_val/out_rdy   : output word handshake
//   out_msg           : packed word, first LFSR bit at bit 0
//   busy              : not in IDLE
//   done              : one-cycle pulse after the final word handshake
module lfsr_word_gen
  import lfsr_word_gen_pkg::*;
#(
  parameter int unsigned nbits = 8,
  parameter int unsigned wbits = 8,
  parameter int unsigned cbits = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_val,
  output logic             cfg_rdy,
  input  logic [nbits-1:0] cfg_tap,
  input  logic [nbits-1:0] cfg_seed,
  input  logic [cbits-1:0] cfg_nwords,
  input  logic             abort,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [wbits-1:0] out_msg,
  output logic             busy,
  output logic             done
);

  localparam int unsigned IW = idx_width(wbits);

  state_t           state;
  logic [cbits-1:0] remaining;
  logic [IW-1:0]    bit_idx;
  logic [wbits-1:0] pack;
  logic [wbits-1:0] pack_next;
  logic [nbits-1:0] tap_q;
  logic [nbits-1:0] seed_q;
  logic             lfsr_out;
  logic             lfsr_rst;
  logic             lfsr_en;

  // The LFSR reset is synchronous; holding it during the async reset keeps
  // it loaded with the (cleared) seed latch until the controller is released.
  assign lfsr_rst = !rst || (state == LOAD);
  assign lfsr_en  = (state == RUN);
  assign cfg_rdy  = (state == IDLE);
  assign busy     = (state != IDLE);

  always_comb begin
    pack_next          = pack;
    pack_next[bit_idx] = lfsr_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      bit_idx   <= '0;
      pack      <= '0;
      tap_q     <= '0;
      seed_q    <= '0;
      out_val   <= 1'b0;
      out_msg   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_val) begin
            tap_q     <= cfg_tap;
            seed_q    <= cfg_seed;
            remaining <= cfg_nwords;
            if (cfg_nwords == '0) begin
              done <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            state   <= RUN;
            bit_idx <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            pack <= pack_next;
            // The last bit goes straight into out_msg via pack_next, so the
            // word is complete on the same edge the final bit is sampled.
            if (bit_idx == IW'(wbits - 1)) begin
              out_msg <= pack_next;
              out_val <= 1'b1;
              state   <= WAIT;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        WAIT: begin
          if (abort) begin
            out_val <= 1'b0;
            state   <= IDLE;
          end else if (out_rdy) begin
            out_val <= 1'b0;
            if (remaining != '0) begin
              remaining <= remaining - 1'b1;
            end
            if (remaining <= cbits'(1)) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state   <= RUN;
              bit_idx <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  lfsr_word_gen_lfsr #(
    .nbits(nbits)
  ) u_lfsr (
    .clk (clk),
    .rst (lfsr_rst),
    .en  (lfsr_en),
    .seed(seed_q),
    .tap (tap_q),
    .out (lfsr_out)
  );

endmodule

// File: tb/tb_lfsr_word_gen.sv
// tb_lfsr_word_gen
//   Self-checking bench for lfsr_word_gen (nbits = wbits = cbits = 8).
//   A behavioural model, driven only by the bench's view of the inputs,
//   predicts words, busy/cfg_rdy, done pulses and backpressure holding.
module tb_lfsr_word_gen;

  logic       clk;
  logic       rst;
  logic       cfg_val;
  logic       cfg_rdy;
  logic [7:0] cfg_tap;
  logic [7:0] cfg_seed;
  logic [7:0] cfg_nwords;
  logic       abort;
  logic       out_val;
  logic       out_rdy;
  logic [7:0] out_msg;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  lfsr_word_gen #(
    .nbits(8),
    .wbits(8),
    .cbits(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_val   (cfg_val),
    .cfg_rdy   (cfg_rdy),
    .cfg_tap   (cfg_tap),
    .cfg_seed  (cfg_seed),
    .cfg_nwords(cfg_nwords),
    .abort     (abort),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out_msg   (out_msg),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One LFSR step: shift toward bit 0, feedback = q[0] xor tapped bits 7..1.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s, input logic [7:0] tap);
    logic fb;
    fb = s[0];
    for (int k = 1; k < 8; k++) if (tap[k]) fb = fb ^ s[k];
    return {fb, s[7:1]};
  endfunction

  // ---------------- behavioural model + compare process ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] ref_q[$];
  bit         m_busy   = 0;
  bit         done_due = 0;
  int         left     = 0;
  int         done_cnt = 0;
  bit         p_val    = 0;
  bit         p_rdy    = 0;
  bit         p_abort  = 0;
  logic [7:0] p_msg    = '0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_out_val", out_val, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      m_busy   = 0;
      done_due = 0;
      left     = 0;
      exp_q.delete();
      p_val    = 0;
      p_rdy    = 0;
      p_abort  = 0;
    end else begin
      if (done) done_cnt++;
      chk("done", done, done_due);
      chk("busy", busy, m_busy);
      chk("cfg_rdy", cfg_rdy, !m_busy);
      if (!m_busy) chk("idle_out_val", out_val, 0);
      if (p_val && !p_rdy && !p_abort) begin
        chk("hold_val", out_val, 1);
        chk("hold_msg", out_msg, p_msg);
      end
      done_due = 0;
      if (m_busy && abort) begin
        m_busy = 0;
        left   = 0;
        exp_q.delete();
      end else if (m_busy && out_val && out_rdy) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          chk("word", out_msg, exp_q.pop_front());
        end
        got_q.push_back(out_msg);
        left--;
        if (left <= 0) begin
          m_busy   = 0;
          done_due = 1;
        end
      end else if (!m_busy && cfg_val) begin
        logic [7:0] s;
        logic [7:0] w;
        s = cfg_seed;
        exp_q.delete();
        for (int n = 0; n < int'(cfg_nwords); n++) begin
          w = '0;
          for (int b = 0; b < 8; b++) begin
            w[b] = s[0];
            s = lfsr_step(s, cfg_tap);
          end
          exp_q.push_back(w);
        end
        left = int'(cfg_nwords);
        if (cfg_nwords == 0) done_due = 1;
        else m_busy = 1;
      end
      p_val   = out_val;
      p_rdy   = out_rdy;
      p_abort = abort;
      p_msg   = out_msg;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_cfg(input logic [7:0] tap, input logic [7:0] seed, input logic [7:0] n);
    @(posedge clk); #1;
    cfg_val = 1'b1; cfg_tap = tap; cfg_seed = seed; cfg_nwords = n;
    @(posedge clk); #1;
    cfg_val = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input bit rnd);
    bit ok;
    ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1;
      else begin
        @(posedge clk); #1;
        if (rnd) out_rdy = 1'($urandom_range(0, 1));
      end
    end
    chk("idle_timeout", ok, 1);
    @(negedge clk);
    chk("exp_left", exp_q.size(), 0);
  endtask

  task automatic wait_val(input int maxc);
    bit ok;
    ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (out_val) ok = 1;
    end
    chk("val_timeout", ok, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int n0;
    bit seen;
    rst = 1'b1; cfg_val = 0; cfg_tap = '0; cfg_seed = '0; cfg_nwords = '0;
    abort = 0; out_rdy = 0;
    #1 rst = 1'b0;
    #1;
    chk("reset_out_val", out_val, 0);
    chk("reset_out_msg", out_msg, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cfg_rdy", cfg_rdy, 1);
    #30 rst = 1'b1;
    @(negedge clk);

    // Pure rotation: two copies of the seed, first out_val in cycle 10.
    out_rdy = 1; done_cnt = 0; got_q.delete();
    send_cfg(8'h00, 8'hA5, 8'd2);
    cyc = 1; seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (out_val) seen = 1; else cyc++;
    end
    chk("first_val_cycle", cyc, 10);
    wait_idle(100, 0);
    chk("rot_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("rot_w0", got_q[0], 8'hA5);
      chk("rot_w1", got_q[1], 8'hA5);
    end
    chk("rot_done_cnt", done_cnt, 1);

    // Taps B8, seed 01: reference run without stalls.
    got_q.delete();
    send_cfg(8'hB8, 8'h01, 8'd4);
    wait_idle(200, 0);
    chk("b8_count", got_q.size(), 4);
    if (got_q.size() >= 2) begin
      chk("b8_w0", got_q[0], 8'h01);
      chk("b8_w1", got_q[1], 8'h67);
    end
    ref_q = got_q;

    // Same config, first word stalled for 5 cycles.
    got_q.delete(); out_rdy = 0;
    send_cfg(8'hB8, 8'h01, 8'd4);
    wait_val(40);
    repeat (5) @(posedge clk);
    #1 out_rdy = 1;
    wait_idle(200, 0);
    chk("stall_count", got_q.size(), ref_q.size());
    for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
      chk("stall_word", got_q[i], ref_q[i]);

    // Zero words: done in cycle 1, never busy.
    got_q.delete();
    send_cfg(8'h5A, 8'h3C, 8'd0);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(negedge clk);
    chk("zero_done_end", done, 0);
    chk("zero_words", got_q.size(), 0);

    // Randomized runs with random backpressure.
    for (int r = 0; r < 15; r++) begin
      send_cfg(8'($urandom), 8'($urandom), 8'($urandom_range(1, 4)));
      wait_idle(400, 1);
      out_rdy = 1;
    end

    // Abort during RUN of word 2.
    got_q.delete(); out_rdy = 1;
    send_cfg(8'hB8, 8'h77, 8'd3);
    wait_val(40);
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    chk("abrun_val", out_val, 0);
    chk("abrun_busy", busy, 0);
    chk("abrun_cfg_rdy", cfg_rdy, 1);
    chk("abrun_words", got_q.size(), 1);
    send_cfg(8'h8E, 8'hC3, 8'd2);
    wait_idle(100, 0);
    chk("abrun_fresh_w0", got_q.size() > 1 ? got_q[1] : 8'h00, 8'hC3);

    // Abort in the same cycle as out_rdy in WAIT: word dropped.
    got_q.delete(); out_rdy = 0;
    send_cfg(8'h1D, 8'h42, 8'd2);
    wait_val(40);
    @(posedge clk); #1;
    n0 = got_q.size();
    out_rdy = 1; abort = 1;
    @(posedge clk); #1 abort = 0;
    @(negedge clk);
    chk("abwait_val", out_val, 0);
    chk("abwait_cfg_rdy", cfg_rdy, 1);
    chk("abwait_words", got_q.size(), n0);
    send_cfg(8'h1D, 8'h99, 8'd1);
    wait_idle(100, 0);
    chk("abwait_fresh", got_q.size() > 0 ? got_q[got_q.size()-1] : 8'h00, 8'h99);

    // Async reset mid-WAIT, then a config held while busy.
    out_rdy = 0;
    send_cfg(8'hB8, 8'h10, 8'd2);
    wait_val(40);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("arst_out_val", out_val, 0);
    chk("arst_out_msg", out_msg, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_cfg_rdy", cfg_rdy, 1);
    @(negedge clk); #2 rst = 1'b1;
    got_q.delete(); out_rdy = 1;
    @(posedge clk); #1;
    cfg_val = 1; cfg_tap = 8'hB8; cfg_seed = 8'h2B; cfg_nwords = 8'd2;
    @(posedge clk); #1;
    cfg_tap = 8'h71; cfg_seed = 8'hE4; cfg_nwords = 8'd5;
    wait_val(40);
    @(posedge clk); #1 cfg_val = 0;
    wait_idle(100, 0);
    chk("held_count", got_q.size(), 2);
    chk("held_w0", got_q.size() > 0 ? got_q[0] : 8'h00, 8'h2B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
